// File: rtl/vliw_pkg.sv
// Shared widths and the refill sequencer state encoding for the VLIW fetch path.
package vliw_pkg;

  localparam int PC_W   = 28;
  localparam int PACK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    INVAL
  } refill_state_t;

  // Beat-index width for a given memory bus width.
  function automatic int beat_bits(input int bus_w);
    return $clog2(PACK_W / bus_w);
  endfunction

endpackage

// File: rtl/pack_assembler.sv
// Collects BUS_W-wide read beats into one 128-bit pack, beat 0 in the low slice.
// Captures one beat per accepted ack; the beat index wraps after the last beat.
module pack_assembler
  import vliw_pkg::*;
#(
  parameter int BUS_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ack,
  input  logic [BUS_W-1:0]  rdata,
  output logic              last_beat,
  output logic [PACK_W-1:0] pack
);

  localparam int BEATS = PACK_W / BUS_W;
  localparam int BW    = beat_bits(BUS_W);

  logic [BW-1:0]     beat_q, beat_d;
  logic [PACK_W-1:0] buf_q, buf_d;

  always_comb begin
    beat_d = beat_q;
    buf_d  = buf_q;
    if (clear) begin
      beat_d = '0;
    end else if (ack) begin
      buf_d[beat_q*BUS_W +: BUS_W] = rdata;
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      buf_q  <= '0;
    end else begin
      beat_q <= beat_d;
      buf_q  <= buf_d;
    end
  end

  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign pack      = buf_q;

endmodule

// File: rtl/icache_refill.sv
// Instruction-pack cache miss handler: fetches a pack in BUS_W beats, writes it back, serialises flushes.
// Miss-to-hit is 2+BEATS cycles with zero-wait acks; each beat holds mem_req/mem_addr until its mem_ack.
module icache_refill
  import vliw_pkg::*;
#(
  parameter  int BUS_W = 32,
  localparam int BW    = beat_bits(BUS_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   curr_PC,
  input  logic              fetch_en,
  input  logic              cache_hit,
  input  logic [PACK_W-1:0] cache_entry,
  output logic [PACK_W-1:0] pack_out,
  output logic              pack_valid,
  output logic [PACK_W-1:0] new_entry,
  output logic              entry_valid,
  output logic              cache_invalidate,
  input  logic              inv_req,
  output logic              mem_req,
  output logic [PC_W+BW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BUS_W-1:0]  mem_rdata,
  output logic              busy
);

  refill_state_t     state_q, state_d;
  logic [PC_W-1:0]   tag_q, tag_d;
  logic              inv_pend_q, inv_pend_d;
  logic              abort_q, abort_d;
  logic              mem_req_q, mem_req_d;
  logic [PC_W+BW-1:0] mem_addr_q, mem_addr_d;
  logic              cache_inv_q, cache_inv_d;
  logic              busy_q, busy_d;

  logic              asm_clear;
  logic              ack_acc;
  logic              last_beat;
  logic [PACK_W-1:0] pack_buf;

  // mem_req_q is only ever high in FETCH, so this is the accepted-beat strobe.
  assign ack_acc = mem_ack && mem_req_q;

  pack_assembler #(.BUS_W(BUS_W)) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .ack       (ack_acc),
    .rdata     (mem_rdata),
    .last_beat (last_beat),
    .pack      (pack_buf)
  );

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cache_inv_d = 1'b0;
    asm_clear   = 1'b0;
    inv_pend_d  = inv_pend_q | inv_req;
    abort_d     = abort_q | ((state_q == FETCH) && (curr_PC != tag_q));

    case (state_q)
      IDLE: begin
        if (inv_pend_q || inv_req) begin
          state_d     = INVAL;
          cache_inv_d = 1'b1;
        end else if (fetch_en && !cache_hit) begin
          state_d    = FETCH;
          tag_d      = curr_PC;
          abort_d    = 1'b0;
          asm_clear  = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = {curr_PC, {BW{1'b0}}};
        end
      end
      FETCH: begin
        // A redirect only takes effect once the beat in flight has been acked.
        if (ack_acc) begin
          if (abort_d) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end else if (last_beat) begin
            state_d   = WRITE;
            mem_req_d = 1'b0;
          end else begin
            mem_addr_d[BW-1:0] = mem_addr_q[BW-1:0] + 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      INVAL: begin
        state_d    = IDLE;
        inv_pend_d = inv_req;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) || inv_pend_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      inv_pend_q  <= 1'b0;
      abort_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      cache_inv_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      inv_pend_q  <= inv_pend_d;
      abort_q     <= abort_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cache_inv_q <= cache_inv_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_addr         = mem_addr_q;
  assign cache_invalidate = cache_inv_q;
  assign busy             = busy_q;
  assign new_entry        = pack_buf;
  assign entry_valid      = (state_q == WRITE) && (curr_PC == tag_q) && !abort_q &&
                            !inv_pend_q && !inv_req;
  assign pack_out         = cache_entry;
  assign pack_valid       = fetch_en && cache_hit && (state_q == IDLE) && !inv_pend_q && !inv_req;

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboarded bench for icache_refill with BUS_W=32 and a wait-state-programmable memory responder.
module tb_icache_refill;

  localparam int BUS_W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [27:0]  curr_PC;
  logic         fetch_en;
  logic         cache_hit;
  logic [127:0] cache_entry;
  logic [127:0] pack_out;
  logic         pack_valid;
  logic [127:0] new_entry;
  logic         entry_valid;
  logic         cache_invalidate;
  logic         inv_req;
  logic         mem_req;
  logic [29:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         busy;

  icache_refill #(.BUS_W(BUS_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .curr_PC          (curr_PC),
    .fetch_en         (fetch_en),
    .cache_hit        (cache_hit),
    .cache_entry      (cache_entry),
    .pack_out         (pack_out),
    .pack_valid       (pack_valid),
    .new_entry        (new_entry),
    .entry_valid      (entry_valid),
    .cache_invalidate (cache_invalidate),
    .inv_req          (inv_req),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [29:0]  exp_addr[$];
  logic [127:0] exp_entry[$];
  int beats_seen   = 0;
  int entries_seen = 0;
  int invs_seen    = 0;

  localparam logic [127:0] FULL_PACK = 128'h44444444_33333333_22222222_11111111;
  logic [31:0] mem_data [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Memory responder: acks each beat after wait_cyc idle cycles.
  int wait_cyc = 0;
  int wcnt     = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_req) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else begin
        if (mem_ack) wcnt = 0;
        mem_ack = (wcnt >= wait_cyc);
        if (!mem_ack) wcnt++;
      end
      mem_rdata = mem_data[mem_addr[1:0]];
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and cache write.
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  logic [29:0] prev_addr = '0;
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      beats_seen++;
      if (exp_addr.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat: got addr %0h, expected no beat", mem_addr);
      end else begin
        check("beat_addr", mem_addr, exp_addr.pop_front());
      end
    end
    if (entry_valid) begin
      entries_seen++;
      if (exp_entry.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got entry %0h, expected no write", new_entry);
      end else begin
        check("new_entry", new_entry, exp_entry.pop_front());
      end
    end
    if (cache_invalidate) begin
      invs_seen++;
      check("inv_write_exclusive", entry_valid, 1'b0);
    end
    if (prev_req && !prev_ack && !prev_rst) begin
      check("req_held", mem_req, 1'b1);
      check("addr_held", mem_addr, prev_addr);
    end
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_rst  = rst;
    prev_addr = mem_addr;
  end

  task automatic push_beats(input logic [27:0] pc, input int n);
    for (int k = 0; k < n; k++) exp_addr.push_back({pc, 2'(k)});
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 60 && beats_seen < n; i++) tick();
    check("beats_reached", beats_seen, n);
  endtask

  initial begin
    int ev, rc, last_req, inv_c, pv_early, e0, i0;
    rst = 1'b1; curr_PC = '0; fetch_en = 1'b0; cache_hit = 1'b0;
    cache_entry = '0; inv_req = 1'b0;
    repeat (2) tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_entry_valid", entry_valid, 1'b0);
    check("rst_cache_inv", cache_invalidate, 1'b0);
    check("rst_pack_valid", pack_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_addr", mem_addr, 30'h0);
    check("rst_new_entry", new_entry, 128'h0);
    rst = 1'b0;
    tick();

    // Cold miss, zero-wait.
    wait_cyc = 0;
    exp_addr.push_back(30'h40); exp_addr.push_back(30'h41);
    exp_addr.push_back(30'h42); exp_addr.push_back(30'h43);
    exp_entry.push_back(FULL_PACK);
    curr_PC = 28'h0000010; fetch_en = 1'b1; cache_hit = 1'b0;
    ev = -1; rc = -1;
    for (int c = 1; c <= 12 && ev < 0; c++) begin
      tick();
      if (mem_req && rc < 0) rc = c;
      if (entry_valid) ev = c;
    end
    check("cold_req_cycle", rc, 1);
    check("cold_write_cycle", ev, 5);
    check("cold_pv_during_write", pack_valid, 1'b0);
    tick();
    cache_hit = 1'b1; cache_entry = FULL_PACK;
    #1;
    check("cold_pack_valid_c6", pack_valid, 1'b1);
    check("cold_pack_out", pack_out, FULL_PACK);
    check("cold_busy_idle", busy, 1'b0);
    fetch_en = 1'b0; cache_hit = 1'b0;
    tick();

    // Wait states: 3 idle cycles per beat.
    wait_cyc = 3; beats_seen = 0;
    push_beats(28'h0ABCDE0, 4);
    exp_entry.push_back(FULL_PACK);
    curr_PC = 28'h0ABCDE0; fetch_en = 1'b1;
    ev = -1;
    for (int c = 1; c <= 40 && ev < 0; c++) begin
      tick();
      if (entry_valid) ev = c;
    end
    fetch_en = 1'b0;
    check("ws_write_cycle", ev, 17);
    check("ws_captures", beats_seen, 4);
    repeat (2) tick();

    // Redirect after beat 0 completes: beat 1 finishes, nothing more.
    wait_cyc = 2; beats_seen = 0; e0 = entries_seen;
    push_beats(28'h0123450, 2);
    curr_PC = 28'h0123450; fetch_en = 1'b1;
    wait_beats(1);
    curr_PC = 28'h0999990; fetch_en = 1'b0;
    repeat (20) tick();
    check("redir_beats", beats_seen, 2);
    check("redir_no_write", entries_seen, e0);
    check("redir_req_low", mem_req, 1'b0);
    check("redir_idle", busy, 1'b0);

    // Invalidate while beat 2 is in flight.
    wait_cyc = 1; beats_seen = 0; e0 = entries_seen; i0 = invs_seen;
    push_beats(28'h0555550, 4);
    curr_PC = 28'h0555550; fetch_en = 1'b1; cache_hit = 1'b0;
    wait_beats(2);
    inv_req = 1'b1;
    last_req = cyc;
    tick();
    inv_req = 1'b0; cache_hit = 1'b1;
    inv_c = -1; pv_early = 0;
    for (int n = 0; n < 30 && inv_c < 0; n++) begin
      tick();
      if (mem_req) last_req = cyc;
      if (cache_invalidate) inv_c = cyc;
      else if (pack_valid) pv_early++;
    end
    check("invr_beats", beats_seen, 4);
    check("invr_write_dropped", entries_seen, e0);
    check("invr_inv_after_write", (inv_c - last_req == 2) || (inv_c - last_req == 3), 1'b1);
    check("invr_pv_held_low", pv_early, 0);
    tick();
    check("invr_pv_after_inv", pack_valid, 1'b1);
    check("invr_inv_count", invs_seen - i0, 1);
    fetch_en = 1'b0; cache_hit = 1'b0;
    tick();

    // Coincident invalidate and miss: invalidate first, then the refill.
    wait_cyc = 0;
    push_beats(28'h0777770, 4);
    exp_entry.push_back(FULL_PACK);
    curr_PC = 28'h0777770; fetch_en = 1'b1; cache_hit = 1'b0; inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    check("prio_inv_next", cache_invalidate, 1'b1);
    check("prio_no_req_yet", mem_req, 1'b0);
    ev = -1; rc = -1;
    for (int c = 2; c <= 14 && ev < 0; c++) begin
      tick();
      if (mem_req && rc < 0) rc = c;
      if (entry_valid) ev = c;
    end
    fetch_en = 1'b0;
    check("prio_req_cycle", rc, 3);
    check("prio_write_cycle", ev, 7);
    repeat (2) tick();

    // Reset while beat 2 is outstanding.
    wait_cyc = 2; beats_seen = 0;
    push_beats(28'h0333330, 2);
    curr_PC = 28'h0333330; fetch_en = 1'b1;
    wait_beats(2);
    check("rstf_req_before", mem_req, 1'b1);
    rst = 1'b1; fetch_en = 1'b0;
    tick();
    check("rstf_mem_req", mem_req, 1'b0);
    check("rstf_busy", busy, 1'b0);
    check("rstf_entry_valid", entry_valid, 1'b0);
    check("rstf_cache_inv", cache_invalidate, 1'b0);
    check("rstf_pack_valid", pack_valid, 1'b0);
    rst = 1'b0;
    repeat (4) tick();
    check("rstf_no_late_beat", beats_seen, 2);

    check("sb_addr_drained", exp_addr.size(), 0);
    check("sb_entry_drained", exp_entry.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
